// File: rtl/route_comp_stage_pkg.sv
// Shared routing definitions: port indices, productive-vector width and flit field offsets.
// Flit layout, MSB first: {hop, dst_y, dst_x, data}.
package route_comp_stage_pkg;

    localparam int unsigned PORT_N     = 0;
    localparam int unsigned PORT_E     = 1;
    localparam int unsigned PORT_S     = 2;
    localparam int unsigned PORT_W     = 3;
    localparam int unsigned PORT_LOCAL = 4;
    localparam int unsigned NUM_PORT   = PORT_LOCAL + 1;
    localparam int unsigned NUM_LINK   = NUM_PORT - 1;
    localparam int unsigned WIDTH_PV   = NUM_LINK;

    function automatic int unsigned dst_x_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned dst_y_lsb(input int unsigned data_w, input int unsigned coord_w);
        return data_w + coord_w;
    endfunction

    function automatic int unsigned hop_lsb(input int unsigned data_w, input int unsigned coord_w);
        return data_w + 2 * coord_w;
    endfunction

    function automatic int unsigned flit_w(input int unsigned hop_w, input int unsigned coord_w,
                                           input int unsigned data_w);
        return hop_w + 2 * coord_w + data_w;
    endfunction

endpackage

// File: rtl/route_comp_stage_if.sv
// Link-side bundle of the route computation stage: four link slots, local injection, routed outputs.
interface route_comp_stage_if
    import route_comp_stage_pkg::*;
#(
    parameter int unsigned COORD_W = 3,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned HOP_W   = 8
) ();
    localparam int unsigned FLIT_W = flit_w(HOP_W, COORD_W, DATA_W);

    logic [COORD_W-1:0]           my_x;
    logic [COORD_W-1:0]           my_y;
    logic [NUM_LINK-1:0]          in_valid;
    logic [NUM_LINK*FLIT_W-1:0]   in_flit;
    logic                         inj_valid;
    logic [FLIT_W-1:0]            inj_flit;
    logic                         inj_ready;
    logic [NUM_LINK-1:0]          out_valid;
    logic [NUM_LINK*FLIT_W-1:0]   out_flit;
    logic [NUM_LINK*WIDTH_PV-1:0] out_pv;
    logic [NUM_LINK-1:0]          out_eject;
    logic                         starve;

    modport master (
        output my_x, my_y, in_valid, in_flit, inj_valid, inj_flit,
        input  inj_ready, out_valid, out_flit, out_pv, out_eject, starve
    );

    modport slave (
        input  my_x, my_y, in_valid, in_flit, inj_valid, inj_flit,
        output inj_ready, out_valid, out_flit, out_pv, out_eject, starve
    );

endinterface

// File: rtl/route_comp_stage_route_xy.sv
// Minimal XY productive-direction compare for one flit against the local router coordinates.
module route_xy
    import route_comp_stage_pkg::*;
#(
    parameter int unsigned COORD_W = 3
) (
    input  logic [COORD_W-1:0]  dst_x,
    input  logic [COORD_W-1:0]  dst_y,
    input  logic [COORD_W-1:0]  my_x,
    input  logic [COORD_W-1:0]  my_y,
    output logic [WIDTH_PV-1:0] pv,
    output logic                eject
);

    // Bit positions match the port allocator request vector so pv needs no remapping downstream.
    always_comb begin
        pv         = '0;
        pv[PORT_E] = dst_x > my_x;
        pv[PORT_W] = dst_x < my_x;
        pv[PORT_N] = dst_y > my_y;
        pv[PORT_S] = dst_y < my_y;
        eject      = (dst_x == my_x) && (dst_y == my_y);
    end

endmodule

// File: rtl/route_comp_stage.sv
// Route computation stage: merges local injection into a free link slot, computes the productive
// vector and eject flag per slot, bumps the hop count and registers everything with one cycle latency.
module route_comp_stage
    import route_comp_stage_pkg::*;
#(
    parameter int unsigned COORD_W   = 3,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned HOP_W     = 8,
    parameter int unsigned STARVE_TH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    route_comp_stage_if.slave link
);

    localparam int unsigned FLIT_W   = flit_w(HOP_W, COORD_W, DATA_W);
    localparam int unsigned DSTX_LSB = dst_x_lsb(DATA_W);
    localparam int unsigned DSTY_LSB = dst_y_lsb(DATA_W, COORD_W);
    localparam int unsigned HOP_LSB  = hop_lsb(DATA_W, COORD_W);
    localparam int unsigned CNT_W    = $clog2(STARVE_TH + 1);

    logic                       inj_ready_c;
    logic                       inj_found_c;
    logic [NUM_LINK-1:0]        inj_sel_c;
    logic [NUM_LINK-1:0]        slot_valid_c;
    logic [FLIT_W-1:0]          slot_flit_c [NUM_LINK];
    logic [FLIT_W-1:0]          next_flit_c [NUM_LINK];
    logic [WIDTH_PV-1:0]        pv_c        [NUM_LINK];
    logic [NUM_LINK-1:0]        eject_c;
    logic [HOP_W-1:0]           hop_c       [NUM_LINK];
    logic [CNT_W-1:0]           starve_cnt;
    logic [CNT_W-1:0]           starve_cnt_next_c;

    logic [NUM_LINK-1:0]          out_valid;
    logic [NUM_LINK*FLIT_W-1:0]   out_flit;
    logic [NUM_LINK*WIDTH_PV-1:0] out_pv;
    logic [NUM_LINK-1:0]          out_eject;
    logic                         starve;

    // Injection only takes a slot no link flit occupies; held off entirely while in reset.
    assign inj_ready_c    = reset_n & link.inj_valid & ~(&link.in_valid);
    assign link.inj_ready = inj_ready_c;

    // Lowest-index free slot receives the injected flit.
    always_comb begin
        inj_sel_c   = '0;
        inj_found_c = 1'b0;
        for (int i = 0; i < NUM_LINK; i++) begin
            if (!link.in_valid[i] && !inj_found_c) begin
                inj_sel_c[i] = inj_ready_c;
                inj_found_c  = 1'b1;
            end
        end
    end

    assign slot_valid_c = link.in_valid | inj_sel_c;

    always_comb begin
        for (int i = 0; i < NUM_LINK; i++) begin
            slot_flit_c[i] = inj_sel_c[i] ? link.inj_flit : link.in_flit[i*FLIT_W +: FLIT_W];
            hop_c[i]       = slot_flit_c[i][HOP_LSB +: HOP_W];
            if (!(&hop_c[i])) begin
                hop_c[i] = hop_c[i] + HOP_W'(1);
            end
            next_flit_c[i] = {hop_c[i], slot_flit_c[i][HOP_LSB-1:0]};
        end
    end

    for (genvar g = 0; g < NUM_LINK; g++) begin : g_route
        route_xy #(
            .COORD_W (COORD_W)
        ) u_route_xy (
            .dst_x (slot_flit_c[g][DSTX_LSB +: COORD_W]),
            .dst_y (slot_flit_c[g][DSTY_LSB +: COORD_W]),
            .my_x  (link.my_x),
            .my_y  (link.my_y),
            .pv    (pv_c[g]),
            .eject (eject_c[g])
        );
    end

    // Consecutive blocked-injection cycles, saturating at the threshold.
    always_comb begin
        starve_cnt_next_c = '0;
        if (link.inj_valid && !inj_ready_c) begin
            starve_cnt_next_c = (starve_cnt == CNT_W'(STARVE_TH)) ? starve_cnt
                                                                   : starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= '0;
            out_flit   <= '0;
            out_pv     <= '0;
            out_eject  <= '0;
            starve     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_next_c;
            starve     <= starve_cnt_next_c >= CNT_W'(STARVE_TH);
            for (int i = 0; i < NUM_LINK; i++) begin
                out_valid[i]                    <= slot_valid_c[i];
                out_pv[i*WIDTH_PV +: WIDTH_PV]  <= slot_valid_c[i] ? pv_c[i] : '0;
                out_eject[i]                    <= slot_valid_c[i] & eject_c[i];
                if (slot_valid_c[i]) begin
                    out_flit[i*FLIT_W +: FLIT_W] <= next_flit_c[i];
                end
            end
        end
    end

    assign link.out_valid = out_valid;
    assign link.out_flit  = out_flit;
    assign link.out_pv    = out_pv;
    assign link.out_eject = out_eject;
    assign link.starve    = starve;

endmodule

// File: tb/tb_route_comp_stage.sv
// Directed plus random bench for route_comp_stage: expected outputs are queued when inputs are driven
// and compared one cycle later; reset behaviour and injection starvation checked directly.
module tb_route_comp_stage;

    localparam int unsigned FW = 46;

    typedef struct {
        logic [3:0]      valid;
        logic [15:0]     pv;
        logic [3:0]      eject;
        logic [4*FW-1:0] flit;
        logic            starve;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    route_comp_stage_if #(.COORD_W(3), .DATA_W(32), .HOP_W(8)) link ();

    route_comp_stage #(
        .COORD_W   (3),
        .DATA_W    (32),
        .HOP_W     (8),
        .STARVE_TH (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .link    (link)
    );

    exp_t            sb [$];
    logic [4*FW-1:0] last_flit;
    int              cnt;
    int              vectors;
    int              miscompares;
    logic [2:0]      mx;
    logic [2:0]      my;

    function automatic logic [FW-1:0] mk(input logic [7:0] hop, input logic [2:0] dy,
                                         input logic [2:0] dx, input logic [31:0] data);
        return {hop, dy, dx, data};
    endfunction

    // Expected productive vector: bit0 N(y up), bit1 E(x up), bit2 S(y down), bit3 W(x down).
    function automatic logic [3:0] ref_pv(input logic [2:0] dx, input logic [2:0] dy,
                                          input logic [2:0] ax, input logic [2:0] ay);
        logic [3:0] r;
        r = 4'b0000;
        if (int'(dx) > int'(ax)) r = r | 4'b0010;
        if (int'(dx) < int'(ax)) r = r | 4'b1000;
        if (int'(dy) > int'(ay)) r = r | 4'b0001;
        if (int'(dy) < int'(ay)) r = r | 4'b0100;
        return r;
    endfunction

    function automatic logic [FW-1:0] ref_next(input logic [FW-1:0] f);
        logic [7:0] h;
        h = f[45:38];
        if (h != 8'hFF) h = h + 8'd1;
        return {h, f[37:0]};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the model result, then check the registered outputs.
    task automatic apply(input logic [3:0] vin, input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                         input logic [FW-1:0] f2, input logic [FW-1:0] f3,
                         input logic iv, input logic [FW-1:0] inf);
        logic [FW-1:0] f [4];
        logic [FW-1:0] s;
        exp_t          e;
        exp_t          got;
        logic          rdy;
        int            slot;
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        link.in_valid  = vin;
        link.in_flit   = {f3, f2, f1, f0};
        link.inj_valid = iv;
        link.inj_flit  = inf;
        rdy  = iv && (vin != 4'hF);
        slot = -1;
        for (int i = 0; i < 4; i++) if (!vin[i] && slot < 0) slot = i;
        for (int i = 0; i < 4; i++) begin
            s          = f[i];
            e.valid[i] = vin[i];
            if (rdy && i == slot) begin
                s          = inf;
                e.valid[i] = 1'b1;
            end
            if (e.valid[i]) begin
                e.pv[i*4 +: 4]    = ref_pv(s[34:32], s[37:35], mx, my);
                e.eject[i]        = (s[34:32] == mx) && (s[37:35] == my);
                e.flit[i*FW +: FW] = ref_next(s);
            end else begin
                e.pv[i*4 +: 4]    = 4'b0000;
                e.eject[i]        = 1'b0;
                e.flit[i*FW +: FW] = last_flit[i*FW +: FW];
            end
        end
        if (iv && !rdy) begin
            if (cnt < 16) cnt++;
        end else begin
            cnt = 0;
        end
        e.starve  = (cnt >= 16);
        last_flit = e.flit;
        sb.push_back(e);
        #1;
        chk("inj_ready", 256'(link.inj_ready), 256'(rdy));
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("out_valid", 256'(link.out_valid), 256'(got.valid));
        chk("out_pv",    256'(link.out_pv),    256'(got.pv));
        chk("out_eject", 256'(link.out_eject), 256'(got.eject));
        chk("out_flit",  256'(link.out_flit),  256'(got.flit));
        chk("starve",    256'(link.starve),    256'(got.starve));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4*FW-1:0] of;
        logic [FW-1:0]   z;
        logic [FW-1:0]   rf [4];
        z           = '0;
        vectors     = 0;
        miscompares = 0;
        cnt         = 0;
        last_flit   = '0;
        mx          = 3'd2;
        my          = 3'd2;
        link.my_x   = mx;
        link.my_y   = my;

        // Reset held across edges with live traffic: outputs stay cleared, no injection accepted.
        reset_n        = 1'b0;
        link.in_valid  = 4'b0110;
        link.in_flit   = {z, mk(8'd1, 3'd4, 3'd4, 32'h1), mk(8'd1, 3'd0, 3'd0, 32'h2), z};
        link.inj_valid = 1'b1;
        link.inj_flit  = mk(8'd0, 3'd1, 3'd1, 32'h3);
        #1;
        chk("rst_inj_ready", 256'(link.inj_ready), 256'(0));
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 256'(link.out_valid), 256'(0));
        chk("rst_out_flit",  256'(link.out_flit),  256'(0));
        chk("rst_starve",    256'(link.starve),    256'(0));
        #1 reset_n = 1'b1;

        // my=(2,2), slot1 dst=(4,1) hop=5 -> E+S, hop 6.
        apply(4'b0010, z, mk(8'd5, 3'd1, 3'd4, 32'hCAFE_0001), z, z, 1'b0, z);
        of = link.out_flit;
        chk("r24_valid", 256'(link.out_valid),   256'(4'b0010));
        chk("r24_pv1",   256'(link.out_pv[7:4]), 256'(4'b0110));
        chk("r24_hop1",  256'(of[84 +: 8]),      256'(8'd6));

        // Slot0 addressed to this router -> eject, empty pv.
        apply(4'b0001, mk(8'd0, 3'd2, 3'd2, 32'hE7EC_7000), z, z, z, 1'b0, z);
        chk("r25_eject0", 256'(link.out_eject[0]), 256'(1));
        chk("r25_pv0",    256'(link.out_pv[3:0]),  256'(0));

        // Injection into lowest free slot (slot1), dst=(0,2) -> W only.
        apply(4'b0101, mk(8'd1, 3'd7, 3'd2, 32'hA), z, mk(8'd2, 3'd2, 3'd7, 32'hB), z,
              1'b1, mk(8'd0, 3'd2, 3'd0, 32'h1111_2222));
        chk("r26_valid", 256'(link.out_valid),   256'(4'b0111));
        chk("r26_pv1",   256'(link.out_pv[7:4]), 256'(4'b1000));

        // Hop saturation.
        apply(4'b0100, z, z, mk(8'hFF, 3'd0, 3'd5, 32'h5A5A), z, 1'b0, z);
        of = link.out_flit;
        chk("r28_hop2", 256'(of[130 +: 8]), 256'(8'hFF));

        // Self-addressed injection with all links idle lands in slot0 and ejects.
        apply(4'b0000, z, z, z, z, 1'b1, mk(8'd3, 3'd2, 3'd2, 32'h5E1F));
        chk("r17_eject0", 256'(link.out_eject), 256'(4'b0001));

        // All links busy while injecting: blocked for 16 cycles then starve.
        for (int k = 0; k < 16; k++) begin
            apply(4'b1111, mk(8'(k), 3'd5, 3'd1, 32'(k)), mk(8'd0, 3'd0, 3'd6, 32'h1),
                  mk(8'd9, 3'd2, 3'd2, 32'h2), mk(8'd4, 3'd3, 3'd0, 32'h3),
                  1'b1, mk(8'd0, 3'd4, 3'd4, 32'hBEEF));
            if (k == 14) chk("r27_starve_early", 256'(link.starve), 256'(0));
        end
        chk("r27_starve_set", 256'(link.starve), 256'(1));
        apply(4'b1110, z, mk(8'd0, 3'd0, 3'd6, 32'h1), mk(8'd9, 3'd2, 3'd2, 32'h2),
              mk(8'd4, 3'd3, 3'd0, 32'h3), 1'b1, mk(8'd0, 3'd4, 3'd4, 32'hBEEF));
        chk("r27_starve_clr", 256'(link.starve), 256'(0));
        chk("r27_inj_slot0",  256'(link.out_valid), 256'(4'b1111));

        // Random traffic at a different router position.
        mx = 3'd5; my = 3'd1;
        link.my_x = mx; link.my_y = my;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 4; i++)
                rf[i] = mk((k % 7 == 0) ? 8'hFF : 8'($urandom), 3'($urandom), 3'($urandom), $urandom);
            apply(4'($urandom), rf[0], rf[1], rf[2], rf[3], 1'($urandom),
                  mk(8'($urandom), 3'($urandom), 3'($urandom), $urandom));
        end

        // Reset asserted mid-stream with all slots valid: outputs clear without a clock edge.
        apply(4'b1111, mk(8'd1, 3'd0, 3'd0, 32'h10), mk(8'd2, 3'd7, 3'd7, 32'h20),
              mk(8'd3, 3'd1, 3'd5, 32'h30), mk(8'd4, 3'd2, 3'd3, 32'h40), 1'b1, z);
        link.in_valid  = 4'b1110;
        link.inj_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("r29_valid",     256'(link.out_valid), 256'(0));
        chk("r29_pv",        256'(link.out_pv),    256'(0));
        chk("r29_eject",     256'(link.out_eject), 256'(0));
        chk("r29_flit",      256'(link.out_flit),  256'(0));
        chk("r29_starve",    256'(link.starve),    256'(0));
        chk("r29_inj_ready", 256'(link.inj_ready), 256'(0));
        last_flit = '0;
        cnt       = 0;
        sb.delete();
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("r19_no_capture", 256'(link.out_valid), 256'(0));
        apply(4'b1000, z, z, z, mk(8'd0, 3'd6, 3'd5, 32'h77), 1'b1, mk(8'd7, 3'd1, 3'd0, 32'h88));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/route_comp_stage.md
ROUTE_COMP_STAGE -- requirements
Module: route_comp_stage

Interface
REQ-001 SHALL have parameter COORD_W, default 3, width of each X/Y coordinate field.
REQ-002 SHALL have parameter DATA_W, default 32, payload width.
REQ-003 SHALL have parameter HOP_W, default 8, hop-count width.
REQ-004 SHALL have parameter STARVE_TH, default 16, injection-wait cycles before starve is asserted.
REQ-005 SHALL have the following ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- my_x, my_y  in  COORD_W each  local router coordinates, quasi-static.
- in_valid  in  4  per-link flit valid; slot 0..3 = N,E,S,W.
- in_flit  in  4*FLIT_W  incoming flits; slot i at bits [i*FLIT_W +: FLIT_W].
- inj_valid  in  1  local injection request.
- inj_flit  in  FLIT_W  local injection flit.
- inj_ready  out  1  injection accepted this cycle (combinational).
- out_valid  out  4  registered per-slot valid.
- out_flit  out  4*FLIT_W  registered flits, hop count updated.
- out_pv  out  4*4  registered productive vector per slot; bit0 N, bit1 E, bit2 S, bit3 W.
- out_eject  out  4  registered per-slot local-destination flag.
- starve  out  1  injection starvation indication.
REQ-006 SHALL use flit layout {hop[HOP_W], dst_y[COORD_W], dst_x[COORD_W], data[DATA_W]}, MSB first; FLIT_W = HOP_W+2*COORD_W+DATA_W.

Function
REQ-007 SHALL register every slot with latency exactly 1 cycle from in_* to out_*.
REQ-008 SHALL compute out_pv per valid slot as: bit1 if dst_x>my_x, bit3 if dst_x<my_x, bit0 if dst_y>my_y, bit2 if dst_y<my_y (unsigned compare); minimal, up to two bits set.
REQ-009 SHALL set out_eject=1 and out_pv=0 when dst_x==my_x and dst_y==my_y.
REQ-010 SHALL increment hop by 1 on each registered flit, saturating at all-ones.
REQ-011 SHALL drive out_valid=0, out_pv=0, out_eject=0 for an invalid slot; out_flit of an invalid slot is don't-care but SHALL hold its previous value.
REQ-012 SHALL assert inj_ready when inj_valid=1 and at least one in_valid bit is 0.
REQ-013 SHALL place an accepted injection flit into the lowest-index free slot, processed by REQ-008..010 identically to link flits.
REQ-014 SHALL never drop or overwrite a link flit; with all four in_valid=1, inj_ready=0.
REQ-015 SHALL count consecutive cycles with inj_valid=1 and inj_ready=0 in a saturating counter; counter SHALL clear on accept or when inj_valid=0.
REQ-016 SHALL assert starve (registered) when the counter reaches STARVE_TH, and deassert it the cycle after the counter clears.
REQ-017 SHALL treat a self-addressed injection flit as a valid slot with out_eject=1.

Reset
REQ-018 SHALL, on reset_n low, asynchronously clear out_valid, out_pv, out_eject, out_flit, starve and the starvation counter to 0.
REQ-019 SHALL, while reset_n is low, drive inj_ready=0; the first capture occurs on the first rising clk edge after reset_n rises.
REQ-020 SHALL discard any flit in flight when reset asserts mid-operation; no partial state remains.

Structure
REQ-021 SHALL take port-index constants (N=0, E=1, S=2, W=3, LOCAL=4), NUM_PORT=5, WIDTH_PV=4 and flit-field offsets from the shared global definitions package.
REQ-022 SHALL instantiate one sub-module, route_xy, four times: combinational dst/my coordinates in, pv[3:0] and eject out.
REQ-023 SHALL keep the out_pv ordering consistent with the last-stage port allocator request vector, so out_pv feeds it without remapping.

Verification
REQ-024 SHALL cover: my=(2,2), slot1 valid dst=(4,1), hop=5 -> next cycle out_valid=4'b0010, pv slot1=4'b0110, hop=6.
REQ-025 SHALL cover: slot0 dst=(2,2) -> out_eject[0]=1, pv slot0=0.
REQ-026 SHALL cover: in_valid=4'b0101, inj_valid=1 dst=(0,2) -> inj_ready=1, injection in slot1, pv slot1=4'b1000.
REQ-027 SHALL cover: in_valid=4'b1111, inj_valid=1 held 16 cycles -> inj_ready=0 throughout, starve=1 after 16 cycles; in_valid=4'b1110 -> accept, starve=0 one cycle later.
REQ-028 SHALL cover: hop=8'hFF in -> hop=8'hFF out.
REQ-029 SHALL cover: reset_n low mid-stream with all slots valid -> all outputs 0 immediately, no clock edge required.
